hand_ctrl: RTL and testbench

Player/dealer hand controller: the requesting end of the deck's `get_card` / `card_rdy` / `card_out` interface. On `new_round` it draws the two opening cards, then serves `hit`/`stand` requests one card at a time. It keeps a running blackjack score with soft-ace handling and flags bust, blackjack, protocol timeout and bad card codes. One instance sits beside the deck for each hand (player, dealer) and reports to the game FSM.

---
 rtl/hand_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hand_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hand_ctrl.sv
// Blackjack hand controller: requests cards from the deck, keeps a soft-ace score
// and reports bust, blackjack, timeout and illegal card codes to the game FSM.
module hand_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_round,
    input  logic       hit,
    input  logic       stand,
    input  logic       card_rdy,
    input  logic [3:0] card_in,
    output logic       get_card,
    output logic [4:0] hand_total,
    output logic [3:0] card_count,
    output logic       busy,
    output logic       playing,
    output logic       done,
    output logic       bust,
    output logic       blackjack,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, REQ, ADD, CHECK, PLAY, DONE} state_t;

    // wait_cnt counts completed REQ cycles, so the last one is TIMEOUT-1
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [4:0] hard_sum_reg;
    logic       has_ace_reg;
    logic [3:0] card_count_reg;
    logic [1:0] deal_left_reg;
    logic [3:0] card_reg;
    logic [7:0] wait_cnt_reg;
    logic       get_card_reg, busy_reg, playing_reg, done_reg;
    logic       bust_reg, blackjack_reg, err_reg;

    logic       card_legal;
    logic [4:0] card_value;

    // Registered outputs are loaded together with the state they belong to
    function automatic logic [3:0] state_outs(input state_t s);
        case (s)
            REQ:        return 4'b1100;
            ADD, CHECK: return 4'b0100;
            PLAY:       return 4'b0010;
            DONE:       return 4'b0001;
            default:    return 4'b0000;
        endcase
    endfunction

    always_comb begin
        card_legal = (card_reg >= 4'd1) && (card_reg <= 4'd11);
        card_value = (card_reg == 4'd11) ? 5'd10 : {1'b0, card_reg};
    end

    assign hand_total = (has_ace_reg && hard_sum_reg <= 5'd11) ? hard_sum_reg + 5'd10
                                                              : hard_sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            hard_sum_reg   <= '0;
            has_ace_reg    <= 1'b0;
            card_count_reg <= '0;
            deal_left_reg  <= '0;
            card_reg       <= '0;
            wait_cnt_reg   <= '0;
            bust_reg       <= 1'b0;
            blackjack_reg  <= 1'b0;
            err_reg        <= 1'b0;
            {get_card_reg, busy_reg, playing_reg, done_reg} <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (new_round) begin
                        hard_sum_reg   <= '0;
                        has_ace_reg    <= 1'b0;
                        card_count_reg <= '0;
                        bust_reg       <= 1'b0;
                        blackjack_reg  <= 1'b0;
                        err_reg        <= 1'b0;
                        deal_left_reg  <= 2'd2;
                        wait_cnt_reg   <= '0;
                        state_reg      <= REQ;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(REQ);
                    end
                end
                REQ: begin
                    if (card_rdy) begin
                        card_reg     <= card_in;
                        wait_cnt_reg <= '0;
                        if (deal_left_reg != 2'd0)
                            deal_left_reg <= deal_left_reg - 2'd1;
                        state_reg    <= ADD;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(ADD);
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(DONE);
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ADD: begin
                    if (!card_legal) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(DONE);
                    end else begin
                        hard_sum_reg   <= hard_sum_reg + card_value;
                        has_ace_reg    <= has_ace_reg | (card_reg == 4'd1);
                        card_count_reg <= card_count_reg + 4'd1;
                        state_reg      <= CHECK;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(CHECK);
                    end
                end
                CHECK: begin
                    if (hard_sum_reg > 5'd21) begin
                        bust_reg  <= 1'b1;
                        state_reg <= DONE;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(DONE);
                    end else if (deal_left_reg != 2'd0) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= REQ;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(REQ);
                    end else if (hand_total == 5'd21) begin
                        blackjack_reg <= (card_count_reg == 4'd2);
                        state_reg     <= DONE;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(DONE);
                    end else begin
                        state_reg <= PLAY;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(PLAY);
                    end
                end
                PLAY: begin
                    if (stand) begin
                        state_reg <= DONE;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(DONE);
                    end else if (hit) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= REQ;
                        {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(REQ);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    {get_card_reg, busy_reg, playing_reg, done_reg} <= state_outs(IDLE);
                end
            endcase
        end
    end

    assign get_card   = get_card_reg;
    assign busy       = busy_reg;
    assign playing    = playing_reg;
    assign done       = done_reg;
    assign bust       = bust_reg;
    assign blackjack  = blackjack_reg;
    assign err        = err_reg;
    assign card_count = card_count_reg;

endmodule

// File: tb/tb_hand_ctrl.sv
// Directed bench for hand_ctrl: a small deck driver answers get_card with
// hand-picked card codes and each hand's outputs are compared to fixed values.
module tb_hand_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_round = 1'b0;
    logic       hit = 1'b0;
    logic       stand = 1'b0;
    logic       card_rdy = 1'b0;
    logic [3:0] card_in = 4'd0;
    logic       get_card;
    logic [4:0] hand_total;
    logic [3:0] card_count;
    logic       busy, playing, done, bust, blackjack, err;

    int n_cmp = 0;
    int n_bad = 0;
    bit saw_play = 1'b0;

    hand_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .new_round  (new_round),
        .hit        (hit),
        .stand      (stand),
        .card_rdy   (card_rdy),
        .card_in    (card_in),
        .get_card   (get_card),
        .hand_total (hand_total),
        .card_count (card_count),
        .busy       (busy),
        .playing    (playing),
        .done       (done),
        .bust       (bust),
        .blackjack  (blackjack),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (playing) saw_play <= 1'b1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        new_round = 1'b1;
        tick();
        new_round = 1'b0;
        saw_play = 1'b0;
        check("start_get_card", get_card, 1);
    endtask

    // Wait (bounded) for a request, deliver one card, then let CHECK resolve
    task automatic give(input logic [3:0] code);
        int k = 0;
        while (!get_card && k < 400) begin
            tick();
            k++;
        end
        if (!get_card) check("get_card_wait", get_card, 1);
        card_in  = code;
        card_rdy = 1'b1;
        tick();
        card_rdy = 1'b0;
        check("rdy_drops_get_card", get_card, 0);
        tick();
        tick();
    endtask

    initial begin
        int k;
        // Reset held two cycles with card_rdy toggling
        card_rdy = 1'b1;
        tick();
        card_rdy = 1'b0;
        tick();
        check("rst_get_card", get_card, 0);
        check("rst_total", hand_total, 0);
        check("rst_count", card_count, 0);
        check("rst_flags", {busy, playing, done, bust, blackjack, err}, 0);
        reset = 1'b0;
        tick();

        // Blackjack: J/Q/K then ace
        start_round();
        give(4'd11);
        check("bj_deal2_get_card", get_card, 1);
        give(4'd1);
        check("bj_total", hand_total, 21);
        check("bj_count", card_count, 2);
        check("bj_flag", blackjack, 1);
        check("bj_done", done, 1);
        check("bj_never_play", saw_play, 0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("done_hit_ignored", get_card, 0);

        // Bust: 10, 6, hit 9
        start_round();
        give(4'd10);
        give(4'd6);
        check("bust_playing", playing, 1);
        check("bust_total16", hand_total, 16);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_get_card", get_card, 1);
        give(4'd9);
        check("bust_flag", bust, 1);
        check("bust_total", hand_total, 25);
        check("bust_count", card_count, 3);
        check("bust_done", done, 1);

        // Soft ace: 1, 5, hit 10, hit 5 -> auto-stand on 21
        start_round();
        give(4'd1);
        give(4'd5);
        check("soft_total", hand_total, 16);
        check("soft_playing", playing, 1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        give(4'd10);
        check("hard_total", hand_total, 16);
        check("hard_playing", playing, 1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        give(4'd5);
        check("auto21_total", hand_total, 21);
        check("auto21_done", done, 1);
        check("auto21_bj", blackjack, 0);
        check("auto21_count", card_count, 4);

        // Timeout: no card_rdy, done exactly 255 cycles after get_card rises
        start_round();
        k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        check("timeout_cycles", k, 255);
        check("timeout_err", err, 1);
        check("timeout_get_card", get_card, 0);

        // Illegal code after one legal card
        start_round();
        give(4'd5);
        give(4'd13);
        check("bad_err", err, 1);
        check("bad_done", done, 1);
        check("bad_count", card_count, 1);
        check("bad_total", hand_total, 5);

        // hit and stand together: stand wins
        start_round();
        check("newround_clears_err", err, 0);
        give(4'd10);
        give(4'd6);
        hit = 1'b1;
        stand = 1'b1;
        tick();
        hit = 1'b0;
        stand = 1'b0;
        check("prio_done", done, 1);
        check("prio_get_card", get_card, 0);
        tick();
        check("prio_no_req", get_card, 0);

        // Reset mid-request, with a card strobe on the same edge
        start_round();
        reset = 1'b1;
        card_in = 4'd7;
        card_rdy = 1'b1;
        tick();
        card_rdy = 1'b0;
        check("midrst_get_card", get_card, 0);
        tick();
        reset = 1'b0;
        card_rdy = 1'b1;
        tick();
        card_rdy = 1'b0;
        tick();
        tick();
        check("midrst_late_rdy_count", card_count, 0);
        check("midrst_late_rdy_total", hand_total, 0);
        check("midrst_idle", {get_card, busy, playing, done, err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
